uart_rx: RTL

UART receiver for 8N1 serial frames, the receive-side counterpart of the team's UART transmitter. It runs on the same 4x-baud clock as the transmitter. It synchronizes the asynchronous `rx` line, validates the start bit, samples 8 data bits LSB first, checks the stop bit, and presents each byte through a valid/acknowledge handshake with sticky overrun and framing-error flags.

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver running on a 4x-baud clock.
// The rx line is synchronized, then each bit is sampled once in its
// middle. Completed bytes are presented through rx_valid / rx_ack, with
// sticky overrun and framing-error flags.
module uart_rx (
    input  logic       clk,
    input  logic       res,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ovr,
    output logic       rx_ferr,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t     state;
    logic       sync_meta;
    logic       rxs;
    logic [1:0] ph;
    logic [2:0] bc;
    logic [7:0] shreg;

    // ph == 1 is mid-bit. Each sample point is 4 clocks after the previous one.
    logic sample_pt;
    logic data_shift;
    logic frame_good;
    logic frame_bad;

    assign sample_pt  = (ph == 2'd1);
    assign data_shift = (state == DATA) && sample_pt;
    assign frame_good = (state == STOP) && sample_pt && rxs;
    assign frame_bad  = (state == STOP) && sample_pt && !rxs;

    // Two-flop synchronizer. It resets to the idle (high) line level.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            sync_meta <= rx;
            rxs       <= sync_meta;
        end
    end

    // Frame FSM with phase and bit counters. busy mirrors "not IDLE".
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            ph    <= 2'd0;
            bc    <= 3'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        ph    <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    // ph+1 at the sample point is 2, which is the entry phase for DATA.
                    ph <= ph + 2'd1;
                    if (sample_pt) begin
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            bc    <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    ph <= ph + 2'd1;
                    if (sample_pt) begin
                        if (bc == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bc <= bc + 3'd1;
                        end
                    end
                end
                STOP: begin
                    ph <= ph + 2'd1;
                    if (sample_pt) begin
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BRK;
                        end
                    end
                end
                BRK: begin
                    // A held-low line must go high again before a new start bit counts.
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Shift register. Each bit captures rxs at its own data sample point, LSB first.
    for (genvar gi = 0; gi < 8; gi++) begin : g_shift
        always_ff @(posedge clk or posedge res) begin
            if (res) begin
                shreg[gi] <= 1'b0;
            end else if (data_shift && (bc == 3'(gi))) begin
                shreg[gi] <= rxs;
            end
        end
    end

    // Output byte and handshake flags. A flag being set wins over a same-cycle ack.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            if (frame_good) begin
                rx_byte  <= shreg;
                rx_valid <= 1'b1;
                rx_ovr   <= rx_ack ? 1'b0 : (rx_ovr | rx_valid);
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
                rx_ovr   <= 1'b0;
            end

            if (frame_bad) begin
                rx_ferr <= 1'b1;
            end else if (rx_ack) begin
                rx_ferr <= 1'b0;
            end
        end
    end

endmodule
